csi_rx_packet_handler: RTL and testbench
========================================

Name: csi_rx_packet_handler

Overview:
- Per-packet controller for the CSI-2 receive path, placed after the lane aligner. It takes 32-bit byte-aligned 4-lane words.
- Captures the packet header on start-of-packet and checks or corrects it with the header ECC generator (csi_rx_hdr_ecc, instantiated inside).
- Classifies the packet as short or long, then sequences long-packet payload by word count. Trailing CRC bytes are discarded.
- Outputs feed the pixel unpacker and the frame/line sync logic.

Parameters:
- ERR_CNT_W, 16, width of the saturating uncorrectable-header error counter.
- LP_DT_MIN, 6'h10, lowest data type treated as a long packet; below this is a short packet.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  0 forces IDLE and suppresses all outputs
- in_data  in  32  aligned word; byte0 = in_data[7:0]; header word = {ECC, WC_MSB, WC_LSB, DI}
- in_valid  in  1  in_data qualifier
- in_sync  in  1  with in_valid, marks the first word of a packet (the header)
- sp_valid  out  1  one-cycle strobe: short packet decoded
- lp_start  out  1  one-cycle strobe: long packet header accepted
- pkt_vc  out  2  DI[7:6] of the last accepted header
- pkt_dt  out  6  DI[5:0] of the last accepted header
- pkt_wc  out  16  word count (short-packet data field) of the last accepted header
- pl_data  out  32  payload word
- pl_valid  out  1  payload word qualifier
- pl_be  out  4  byte enables for pl_data; bit i covers pl_data[8i+7:8i]
- pl_last  out  1  with pl_valid, marks the final payload word
- ecc_corr  out  1  strobe: header accepted after a single-bit correction
- ecc_uncorr  out  1  strobe: header rejected
- pkt_trunc  out  1  strobe: in_sync arrived while payload was still outstanding
- err_cnt_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  ERR_CNT_W  saturating count of ecc_uncorr events

Behaviour:
- All outputs are registered. On reset every output is 0 and the FSM is in IDLE.
- Latency: the header word at cycle N produces sp_valid/lp_start/ecc_* at N+1. A payload word at cycle N appears on pl_* at N+1.
- ECC check:
  - calc = ecc(in_data[23:0]); syn = calc[5:0] ^ in_data[29:24].
  - in_data[31:30] are ignored.
  - syn == 0: accept.
  - syn equals ecc(1<<i) for some i in 0..23: flip data bit i, accept, pulse ecc_corr.
  - syn has exactly one bit set (error in an ECC bit): accept, pulse ecc_corr.
  - Any other syn: pulse ecc_uncorr, increment err_cnt (saturating), go to IDLE.
- FSM states: IDLE, PAYLOAD.
  - IDLE -> IDLE: any word without in_sync is dropped. This covers CRC-only words and inter-packet fill.
  - IDLE, header accepted with DT < LP_DT_MIN: pulse sp_valid, update pkt_*, stay in IDLE.
  - IDLE, header accepted with DT >= LP_DT_MIN: pulse lp_start, update pkt_*, load rem = WC.
    - WC == 0: stay in IDLE. No payload is output.
    - WC > 0: go to PAYLOAD.
- PAYLOAD, in_valid and not in_sync:
  - Output the word with pl_valid = 1.
  - rem > 4: pl_be = 4'b1111, rem -= 4.
  - rem <= 4: pl_be = (1<<rem)-1, pl_last = 1, go to IDLE. CRC bytes in the upper lanes of that word are masked by pl_be.
- in_valid = 0: hold all state, no strobes. Gaps of any length are legal in both states.
- in_sync while in PAYLOAD:
  - Pulse pkt_trunc; pl_last is never issued for the aborted packet.
  - That word is processed as a new header in the same cycle.
- enable deasserted mid-packet: go to IDLE immediately; the packet is lost with no strobes. The same applies to reset mid-packet, except reset also clears all outputs.
- Same-cycle ecc_uncorr increment and err_cnt_clr: clear wins.
- rem is 16 bits and must never underflow. The maximum WC of 65535 takes 16384 words.

Optional Feature:
- Macro: CSI_RX_ECC_CORRECT_EN.
- Defined: single-bit correction as described above.
- Undefined: any nonzero syn is uncorrectable (pulse ecc_uncorr, drop the packet); ecc_corr is tied to 0.

Test Plan:
- Frame Start short packet: in_sync word 0x00000000 -> next cycle sp_valid = 1, pkt_dt = 0x00, pkt_wc = 0x0000, no ecc_* strobes.
- Single data-bit error: header 0x00000001 -> syn = 0x07, corrected DI = 0x00, sp_valid = 1 and ecc_corr = 1. With the macro undefined: ecc_uncorr = 1 and err_cnt = 1.
- Double-bit error: header 0x00000003 -> syn = 0x0C, ecc_uncorr = 1, err_cnt increments, no sp_valid. Following non-sync words are all dropped.
- RAW8 long packet: DI = 0x2A, WC = 6, valid ECC, then words W0, W1 (bytes 4,5 followed by 2 CRC bytes), with a 3-cycle in_valid gap between them -> lp_start = 1, pkt_wc = 6; pl W0 with be = 4'hF; pl W1 with be = 4'h3 and pl_last = 1; FSM returns to IDLE.
- Truncation: long header with WC = 16, one payload word, then an in_sync short header 0x00000000 -> pkt_trunc = 1 and sp_valid = 1 in the same cycle, no pl_last.
- Saturation and clear: force err_cnt to all-ones, apply an uncorrectable header -> value holds. Assert err_cnt_clr together with an uncorrectable header -> err_cnt = 0.

Source files
------------

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 receive packet controller: header ECC check, short/long classification, payload sequencing.
// Build macro CSI_RX_ECC_CORRECT_EN enables single-bit header correction (otherwise any ECC error drops the header).
`timescale 1ns/1ps

module csi_rx_hdr_ecc (
    input  logic [23:0] data,
    output logic [5:0]  ecc
);
    // Parity masks for P0..P5; P6/P7 are always zero in CSI-2 and are not produced.
    always_comb begin
        ecc[0] = ^(data & 24'hF12CB7);
        ecc[1] = ^(data & 24'hF2555B);
        ecc[2] = ^(data & 24'h749A6D);
        ecc[3] = ^(data & 24'hB8E38E);
        ecc[4] = ^(data & 24'hDF03F0);
        ecc[5] = ^(data & 24'hEFFC00);
    end
endmodule

module csi_rx_packet_handler #(
    parameter int unsigned ERR_CNT_W = 16,
    parameter logic [5:0]  LP_DT_MIN = 6'h10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_sync,
    output logic                 sp_valid,
    output logic                 lp_start,
    output logic [1:0]           pkt_vc,
    output logic [5:0]           pkt_dt,
    output logic [15:0]          pkt_wc,
    output logic [31:0]          pl_data,
    output logic                 pl_valid,
    output logic [3:0]           pl_be,
    output logic                 pl_last,
    output logic                 ecc_corr,
    output logic                 ecc_uncorr,
    output logic                 pkt_trunc,
    input  logic                 err_cnt_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t               state_q, state_d;
    logic [15:0]          rem_q, rem_d;
    logic                 sp_valid_q, sp_valid_d;
    logic                 lp_start_q, lp_start_d;
    logic [1:0]           pkt_vc_q, pkt_vc_d;
    logic [5:0]           pkt_dt_q, pkt_dt_d;
    logic [15:0]          pkt_wc_q, pkt_wc_d;
    logic [31:0]          pl_data_q, pl_data_d;
    logic                 pl_valid_q, pl_valid_d;
    logic [3:0]           pl_be_q, pl_be_d;
    logic                 pl_last_q, pl_last_d;
    logic                 ecc_corr_q, ecc_corr_d;
    logic                 ecc_uncorr_q, ecc_uncorr_d;
    logic                 pkt_trunc_q, pkt_trunc_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [5:0]  calc;
    logic [5:0]  syn;
    logic [23:0] hdr_fix;
    logic        hdr_ok;
    logic        hdr_corr;
    logic        hdr_evt;
    logic        pl_evt;
    logic        is_short;
    logic [15:0] hdr_wc;

    csi_rx_hdr_ecc u_ecc (
        .data (in_data[23:0]),
        .ecc  (calc)
    );

    assign syn = calc ^ in_data[29:24];

`ifdef CSI_RX_ECC_CORRECT_EN
    // Syndrome produced by a single flipped data bit i, i.e. ecc(1 << i).
    localparam logic [5:0] COL_SYN [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    always_comb begin
        logic [23:0] flip;
        logic        par_err;
        flip = '0;
        for (int i = 0; i < 24; i++) begin
            if (syn == COL_SYN[i]) begin
                flip[i] = 1'b1;
            end
        end
        par_err  = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
        hdr_fix  = in_data[23:0] ^ flip;
        hdr_corr = (flip != 24'd0) || par_err;
        hdr_ok   = (syn == 6'd0) || hdr_corr;
    end
`else
    always_comb begin
        hdr_fix  = in_data[23:0];
        hdr_corr = 1'b0;
        hdr_ok   = (syn == 6'd0);
    end
`endif

    assign is_short = (hdr_fix[5:0] < LP_DT_MIN);
    assign hdr_wc   = hdr_fix[23:8];
    assign hdr_evt  = enable && in_valid && in_sync;
    assign pl_evt   = enable && in_valid && !in_sync && (state_q == PAYLOAD);

    function automatic logic [3:0] tail_be(input logic [2:0] n);
        case (n)
            3'd1:    tail_be = 4'b0001;
            3'd2:    tail_be = 4'b0011;
            3'd3:    tail_be = 4'b0111;
            3'd4:    tail_be = 4'b1111;
            default: tail_be = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            sp_valid_q   <= 1'b0;
            lp_start_q   <= 1'b0;
            pkt_vc_q     <= '0;
            pkt_dt_q     <= '0;
            pkt_wc_q     <= '0;
            pl_data_q    <= '0;
            pl_valid_q   <= 1'b0;
            pl_be_q      <= '0;
            pl_last_q    <= 1'b0;
            ecc_corr_q   <= 1'b0;
            ecc_uncorr_q <= 1'b0;
            pkt_trunc_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            sp_valid_q   <= sp_valid_d;
            lp_start_q   <= lp_start_d;
            pkt_vc_q     <= pkt_vc_d;
            pkt_dt_q     <= pkt_dt_d;
            pkt_wc_q     <= pkt_wc_d;
            pl_data_q    <= pl_data_d;
            pl_valid_q   <= pl_valid_d;
            pl_be_q      <= pl_be_d;
            pl_last_q    <= pl_last_d;
            ecc_corr_q   <= ecc_corr_d;
            ecc_uncorr_q <= ecc_uncorr_d;
            pkt_trunc_q  <= pkt_trunc_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // A sync word is always a header, even when it cuts a payload short.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (hdr_evt) begin
            state_d = IDLE;
            if (hdr_ok && !is_short) begin
                rem_d = hdr_wc;
                if (hdr_wc != 16'd0) begin
                    state_d = PAYLOAD;
                end
            end
        end else if (pl_evt) begin
            if (rem_q > 16'd4) begin
                rem_d = rem_q - 16'd4;
            end else begin
                rem_d   = '0;
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        sp_valid_d   = 1'b0;
        lp_start_d   = 1'b0;
        ecc_corr_d   = 1'b0;
        ecc_uncorr_d = 1'b0;
        pkt_trunc_d  = 1'b0;
        pl_valid_d   = 1'b0;
        pl_last_d    = 1'b0;
        pl_be_d      = '0;
        pl_data_d    = pl_data_q;
        pkt_vc_d     = pkt_vc_q;
        pkt_dt_d     = pkt_dt_q;
        pkt_wc_d     = pkt_wc_q;
        err_cnt_d    = err_cnt_q;
        if (hdr_evt) begin
            pkt_trunc_d = (state_q == PAYLOAD);
            if (hdr_ok) begin
                pkt_vc_d   = hdr_fix[7:6];
                pkt_dt_d   = hdr_fix[5:0];
                pkt_wc_d   = hdr_wc;
                ecc_corr_d = hdr_corr;
                sp_valid_d = is_short;
                lp_start_d = !is_short;
            end else begin
                ecc_uncorr_d = 1'b1;
            end
        end else if (pl_evt) begin
            pl_valid_d = 1'b1;
            pl_data_d  = in_data;
            if (rem_q > 16'd4) begin
                pl_be_d = 4'b1111;
            end else begin
                pl_be_d   = tail_be(rem_q[2:0]);
                pl_last_d = 1'b1;
            end
        end
        // Clear takes priority over a same-cycle increment.
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (ecc_uncorr_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign sp_valid   = sp_valid_q;
    assign lp_start   = lp_start_q;
    assign pkt_vc     = pkt_vc_q;
    assign pkt_dt     = pkt_dt_q;
    assign pkt_wc     = pkt_wc_q;
    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_be      = pl_be_q;
    assign pl_last    = pl_last_q;
    assign ecc_corr   = ecc_corr_q;
    assign ecc_uncorr = ecc_uncorr_q;
    assign pkt_trunc  = pkt_trunc_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Directed bench for csi_rx_packet_handler; err_cnt width is narrowed so saturation is reachable.
`timescale 1ns/1ps

module tb_csi_rx_packet_handler;
    localparam int EW = 3;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_SP   = 7'b1000000;
    localparam logic [6:0] S_LP   = 7'b0100000;
    localparam logic [6:0] S_CORR = 7'b0010000;
    localparam logic [6:0] S_UNC  = 7'b0001000;
    localparam logic [6:0] S_TRNC = 7'b0000100;
    localparam logic [6:0] S_PLV  = 7'b0000010;
    localparam logic [6:0] S_PLL  = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_sync;
    logic          sp_valid, lp_start, pl_valid, pl_last;
    logic          ecc_corr, ecc_uncorr, pkt_trunc;
    logic [1:0]    pkt_vc;
    logic [5:0]    pkt_dt;
    logic [15:0]   pkt_wc;
    logic [31:0]   pl_data;
    logic [3:0]    pl_be;
    logic          err_cnt_clr;
    logic [EW-1:0] err_cnt;
    logic [6:0]    strb;

    int vecs = 0;
    int errs = 0;
    int exp_err = 0;

    assign strb = {sp_valid, lp_start, ecc_corr, ecc_uncorr, pkt_trunc, pl_valid, pl_last};

    always #5 clk = ~clk;

    csi_rx_packet_handler #(.ERR_CNT_W(EW), .LP_DT_MIN(6'h10)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .sp_valid    (sp_valid),
        .lp_start    (lp_start),
        .pkt_vc      (pkt_vc),
        .pkt_dt      (pkt_dt),
        .pkt_wc      (pkt_wc),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_be       (pl_be),
        .pl_last     (pl_last),
        .ecc_corr    (ecc_corr),
        .ecc_uncorr  (ecc_uncorr),
        .pkt_trunc   (pkt_trunc),
        .err_cnt_clr (err_cnt_clr),
        .err_cnt     (err_cnt)
    );

    task automatic apply(input logic [31:0] d, input logic v, input logic s);
        in_data  = d;
        in_valid = v;
        in_sync  = s;
        @(posedge clk);
        #1;
    endtask

    function automatic int bump(input int e);
        return (e == (1 << EW) - 1) ? e : e + 1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; err_cnt_clr = 1'b0;
        apply(32'h0, 1'b0, 1'b0);
        apply(32'h0, 1'b0, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL reset_strobes got=%b exp=%b", strb, S_NONE); errs++; end
        vecs++; if ({pkt_vc, pkt_dt, pkt_wc} !== 24'h0) begin $display("FAIL reset_pkt got=%h exp=0", {pkt_vc, pkt_dt, pkt_wc}); errs++; end
        vecs++; if ({pl_data, pl_be} !== 36'h0) begin $display("FAIL reset_pl got=%h exp=0", {pl_data, pl_be}); errs++; end
        vecs++; if (err_cnt !== '0) begin $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); errs++; end
        #1 rst = 1'b0; enable = 1'b1;
    endtask

    task automatic test_short;
        apply(32'h0000_0000, 1'b1, 1'b1);
        vecs++; if (strb !== S_SP) begin $display("FAIL fs_strobes got=%b exp=%b", strb, S_SP); errs++; end
        vecs++; if ({pkt_dt, pkt_wc} !== 22'h0) begin $display("FAIL fs_pkt got=%h exp=0", {pkt_dt, pkt_wc}); errs++; end
        apply(32'h3200_0502, 1'b1, 1'b1);
        vecs++; if (strb !== S_SP) begin $display("FAIL ls_strobes got=%b exp=%b", strb, S_SP); errs++; end
        vecs++; if ({pkt_vc, pkt_dt, pkt_wc} !== {2'd0, 6'h02, 16'h0005}) begin $display("FAIL ls_pkt got=%h exp=%h", {pkt_vc, pkt_dt, pkt_wc}, {2'd0, 6'h02, 16'h0005}); errs++; end
        // bits 31:30 of the header are not part of the ECC check
        apply(32'hC000_0000, 1'b1, 1'b1);
        vecs++; if (strb !== S_SP) begin $display("FAIL topbits_strobes got=%b exp=%b", strb, S_SP); errs++; end
        vecs++; if (pkt_wc !== 16'h0000) begin $display("FAIL topbits_wc got=%h exp=0000", pkt_wc); errs++; end
    endtask

    task automatic test_ecc_single;
        logic [6:0] e;
`ifdef CSI_RX_ECC_CORRECT_EN
        e = S_SP | S_CORR;
`else
        e = S_UNC;
`endif
        apply(32'h0000_0001, 1'b1, 1'b1);
        if (e == S_UNC) exp_err = bump(exp_err);
        vecs++; if (strb !== e) begin $display("FAIL d0err_strobes got=%b exp=%b", strb, e); errs++; end
        vecs++; if (err_cnt !== EW'(exp_err)) begin $display("FAIL d0err_cnt got=%0d exp=%0d", err_cnt, exp_err); errs++; end
        apply(32'h0100_0000, 1'b1, 1'b1);
        if (e == S_UNC) exp_err = bump(exp_err);
        vecs++; if (strb !== e) begin $display("FAIL p0err_strobes got=%b exp=%b", strb, e); errs++; end
        // valid line-start header with WC bit 8 flipped: syn = 0x1A
        apply(32'h3200_0402, 1'b1, 1'b1);
        if (e == S_UNC) exp_err = bump(exp_err);
        vecs++; if (strb !== e) begin $display("FAIL d8err_strobes got=%b exp=%b", strb, e); errs++; end
`ifdef CSI_RX_ECC_CORRECT_EN
        vecs++; if (pkt_wc !== 16'h0005) begin $display("FAIL d8err_wc got=%h exp=0005", pkt_wc); errs++; end
`endif
        vecs++; if (err_cnt !== EW'(exp_err)) begin $display("FAIL d8err_cnt got=%0d exp=%0d", err_cnt, exp_err); errs++; end
    endtask

    task automatic test_double;
        apply(32'h0000_0003, 1'b1, 1'b1);
        exp_err = bump(exp_err);
        vecs++; if (strb !== S_UNC) begin $display("FAIL dbl_strobes got=%b exp=%b", strb, S_UNC); errs++; end
        vecs++; if (err_cnt !== EW'(exp_err)) begin $display("FAIL dbl_cnt got=%0d exp=%0d", err_cnt, exp_err); errs++; end
        apply(32'h1234_5678, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL dbl_drop1 got=%b exp=%b", strb, S_NONE); errs++; end
        apply(32'h0000_0000, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL dbl_drop2 got=%b exp=%b", strb, S_NONE); errs++; end
    endtask

    task automatic test_raw8;
        apply(32'h2F00_062A, 1'b1, 1'b1);
        vecs++; if (strb !== S_LP) begin $display("FAIL raw8_hdr got=%b exp=%b", strb, S_LP); errs++; end
        vecs++; if ({pkt_dt, pkt_wc} !== {6'h2A, 16'h0006}) begin $display("FAIL raw8_pkt got=%h exp=%h", {pkt_dt, pkt_wc}, {6'h2A, 16'h0006}); errs++; end
        apply(32'h4433_2211, 1'b1, 1'b0);
        vecs++; if (strb !== S_PLV) begin $display("FAIL raw8_w0 got=%b exp=%b", strb, S_PLV); errs++; end
        vecs++; if ({pl_data, pl_be} !== {32'h4433_2211, 4'hF}) begin $display("FAIL raw8_w0data got=%h exp=%h", {pl_data, pl_be}, {32'h4433_2211, 4'hF}); errs++; end
        for (int i = 0; i < 3; i++) begin
            apply(32'hFFFF_FFFF, 1'b0, 1'b1);
            vecs++; if (strb !== S_NONE) begin $display("FAIL raw8_gap%0d got=%b exp=%b", i, strb, S_NONE); errs++; end
        end
        apply(32'hCCDD_6655, 1'b1, 1'b0);
        vecs++; if (strb !== (S_PLV | S_PLL)) begin $display("FAIL raw8_w1 got=%b exp=%b", strb, S_PLV | S_PLL); errs++; end
        vecs++; if ({pl_data, pl_be} !== {32'hCCDD_6655, 4'h3}) begin $display("FAIL raw8_w1data got=%h exp=%h", {pl_data, pl_be}, {32'hCCDD_6655, 4'h3}); errs++; end
        apply(32'hAAAA_AAAA, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL raw8_idle got=%b exp=%b", strb, S_NONE); errs++; end
    endtask

    task automatic test_long_edges;
        apply(32'h1000_002A, 1'b1, 1'b1);
        vecs++; if (strb !== S_LP) begin $display("FAIL wc0_hdr got=%b exp=%b", strb, S_LP); errs++; end
        apply(32'h5555_5555, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL wc0_nopl got=%b exp=%b", strb, S_NONE); errs++; end
        apply(32'h3300_042A, 1'b1, 1'b1);
        vecs++; if (strb !== S_LP) begin $display("FAIL wc4_hdr got=%b exp=%b", strb, S_LP); errs++; end
        apply(32'h0807_0605, 1'b1, 1'b0);
        vecs++; if ({strb, pl_be} !== {S_PLV | S_PLL, 4'hF}) begin $display("FAIL wc4_pl got=%b exp=%b", {strb, pl_be}, {S_PLV | S_PLL, 4'hF}); errs++; end
    endtask

    task automatic test_trunc;
        apply(32'h3600_102A, 1'b1, 1'b1);
        vecs++; if ({strb, pkt_wc} !== {S_LP, 16'd16}) begin $display("FAIL trn_hdr got=%h exp=%h", {strb, pkt_wc}, {S_LP, 16'd16}); errs++; end
        apply(32'h1111_1111, 1'b1, 1'b0);
        vecs++; if ({strb, pl_be} !== {S_PLV, 4'hF}) begin $display("FAIL trn_w0 got=%b exp=%b", {strb, pl_be}, {S_PLV, 4'hF}); errs++; end
        apply(32'h0000_0000, 1'b1, 1'b1);
        vecs++; if (strb !== (S_SP | S_TRNC)) begin $display("FAIL trn_sync got=%b exp=%b", strb, S_SP | S_TRNC); errs++; end
        apply(32'h2222_2222, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL trn_after got=%b exp=%b", strb, S_NONE); errs++; end
    endtask

    task automatic test_enable;
        apply(32'h2F00_062A, 1'b1, 1'b1);
        apply(32'h4433_2211, 1'b1, 1'b0);
        enable = 1'b0;
        apply(32'h6666_6666, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL en_off_pl got=%b exp=%b", strb, S_NONE); errs++; end
        apply(32'h0000_0000, 1'b1, 1'b1);
        vecs++; if (strb !== S_NONE) begin $display("FAIL en_off_hdr got=%b exp=%b", strb, S_NONE); errs++; end
        enable = 1'b1;
        apply(32'h7777_7777, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL en_lost got=%b exp=%b", strb, S_NONE); errs++; end
    endtask

    task automatic test_err_sat;
        for (int i = 0; i < (1 << EW) + 1; i++) begin
            apply(32'h0000_0003, 1'b1, 1'b1);
            exp_err = bump(exp_err);
        end
        vecs++; if (err_cnt !== {EW{1'b1}}) begin $display("FAIL sat_hold got=%0d exp=%0d", err_cnt, (1 << EW) - 1); errs++; end
        vecs++; if (err_cnt !== EW'(exp_err)) begin $display("FAIL sat_model got=%0d exp=%0d", err_cnt, exp_err); errs++; end
        err_cnt_clr = 1'b1;
        apply(32'h0000_0003, 1'b1, 1'b1);
        err_cnt_clr = 1'b0;
        exp_err = 0;
        vecs++; if ({strb, err_cnt} !== {S_UNC, EW'(0)}) begin $display("FAIL clr_wins got=%b exp=%b", {strb, err_cnt}, {S_UNC, EW'(0)}); errs++; end
        apply(32'h0000_0003, 1'b1, 1'b1);
        vecs++; if (err_cnt !== EW'(1)) begin $display("FAIL after_clr got=%0d exp=1", err_cnt); errs++; end
    endtask

    task automatic test_reset_mid;
        apply(32'h2F00_062A, 1'b1, 1'b1);
        apply(32'h4433_2211, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vecs++; if ({strb, pl_data, pl_be, err_cnt} !== '0) begin $display("FAIL rstmid_out got=%h exp=0", {strb, pl_data, pl_be, err_cnt}); errs++; end
        apply(32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        apply(32'h8888_8888, 1'b1, 1'b0);
        vecs++; if (strb !== S_NONE) begin $display("FAIL rstmid_idle got=%b exp=%b", strb, S_NONE); errs++; end
    endtask

    initial begin
        in_data = '0; in_valid = 1'b0; in_sync = 1'b0;
        test_reset();
        test_short();
        test_ecc_single();
        test_double();
        test_raw8();
        test_long_edges();
        test_trunc();
        test_enable();
        test_err_sat();
        test_reset_mid();
        apply(32'h0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
